// File: rtl/hazard_scoreboard.sv
// Hazard-detection and operand-forwarding scoreboard between register read and
// the execute/memory/writeback stages; stalls issue only on unready results.
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 2,
  parameter bit FWD_EN     = 1'b1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [RA_W-1:0]       rs1,
  input  logic [RA_W-1:0]       rs2,
  input  logic [RA_W-1:0]       rd,
  input  logic                  rd_we,
  input  logic                  is_load,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [XLEN-1:0]       rf_rs1_val,
  input  logic [XLEN-1:0]       rf_rs2_val,
  input  logic [DEPTH*XLEN-1:0] stage_res,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic [31:0]           stall_count
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            load;
  } entry_t;

  entry_t sb [DEPTH];

  logic [1:0]      use_src;
  logic [RA_W-1:0] src    [2];
  logic [XLEN-1:0] rf_val [2];
  logic [SEL_W-1:0] sel   [2];
  logic [XLEN-1:0] opv    [2];
  logic [1:0]      src_haz;
  logic            hazard;
  logic            accept;
  entry_t          new_entry;

  assign use_src   = {use_rs2, use_rs1};
  assign src[0]    = rs1;
  assign src[1]    = rs2;
  assign rf_val[0] = rf_rs1_val;
  assign rf_val[1] = rf_rs2_val;

  // NOTE: combinational logic uses blocking assignments and gives every output a
  // default before any conditional update, so no latch can be inferred.
  always_comb begin
    logic hit;
    logic hit_rdy;
    int   hit_idx;
    src_haz = '0;
    for (int n = 0; n < 2; n++) begin
      hit     = 1'b0;
      hit_rdy = 1'b0;
      hit_idx = 0;
      // Scan oldest to youngest so the youngest matching producer wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (use_src[n] && (src[n] != '0) && sb[k].valid && sb[k].we &&
            (sb[k].rd == src[n])) begin
          hit     = 1'b1;
          hit_idx = k;
          hit_rdy = (k >= (sb[k].load ? LOAD_READY : ALU_READY));
        end
      end
      sel[n] = '0;
      opv[n] = rf_val[n];
      if (hit) begin
        if (FWD_EN && hit_rdy) begin
          sel[n] = SEL_W'(hit_idx + 1);
          opv[n] = stage_res[hit_idx*XLEN +: XLEN];
        end else begin
          src_haz[n] = 1'b1;
        end
      end
    end
  end

  assign hazard      = issue_valid && (|src_haz);
  assign issue_ready = !hold && !hazard;
  assign accept      = issue_valid && issue_ready && !flush;
  assign op1         = opv[0];
  assign op2         = opv[1];
  assign fwd_sel1    = sel[0];
  assign fwd_sel2    = sel[1];

  always_comb begin
    new_entry       = '0;
    new_entry.valid = accept;
    new_entry.rd    = rd;
    new_entry.we    = rd_we;
    new_entry.load  = is_load;
  end

  // NOTE: state uses non-blocking assignments, and every scoreboard entry is
  // reset because a stale valid bit would create a phantom hazard.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
      stall_count <= '0;
    end else begin
      if (!hold) begin
        for (int k = 1; k < DEPTH; k++) begin
          sb[k] <= sb[k-1];
          // A flushed stage-0 instruction is dropped instead of advancing.
          if (k == 1 && flush) sb[k].valid <= 1'b0;
        end
        sb[0] <= new_entry;
      end else if (flush) begin
        sb[0].valid <= 1'b0;
      end
      if (hazard && !hold && !flush && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: forwarding and non-forwarding instances share
// stimulus; a queue-based in-flight model is checked every cycle.
module tb_hazard_scoreboard;
  localparam int XLEN = 32, RA_W = 5, DEPTH = 3, AR = 0, LR = 2, SEL_W = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset;
  logic                  issue_valid, use_rs1, use_rs2, rd_we, is_load, hold, flush;
  logic [RA_W-1:0]       rs1, rs2, rd;
  logic [XLEN-1:0]       rf_rs1_val, rf_rs2_val;
  logic [DEPTH*XLEN-1:0] stage_res;

  logic             f_ready, n_ready;
  logic [XLEN-1:0]  f_op1, f_op2, n_op1, n_op2;
  logic [SEL_W-1:0] f_sel1, f_sel2, n_sel1, n_sel2;
  logic [31:0]      f_stall, n_stall;

  hazard_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .ALU_READY(AR),
    .LOAD_READY(LR), .FWD_EN(1'b1)) u_fwd (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(f_ready),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rd_we(rd_we), .is_load(is_load), .hold(hold), .flush(flush),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val), .stage_res(stage_res),
    .op1(f_op1), .op2(f_op2), .fwd_sel1(f_sel1), .fwd_sel2(f_sel2),
    .stall_count(f_stall));

  hazard_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .ALU_READY(AR),
    .LOAD_READY(LR), .FWD_EN(1'b0)) u_nofwd (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(n_ready),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rd_we(rd_we), .is_load(is_load), .hold(hold), .flush(flush),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val), .stage_res(stage_res),
    .op1(n_op1), .op2(n_op2), .fwd_sel1(n_sel1), .fwd_sel2(n_sel2),
    .stall_count(n_stall));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // In-flight instruction list: each record knows how many stages it has advanced.
  typedef struct {
    int              stage;
    logic [RA_W-1:0] rd;
    bit              we;
    bit              load;
  } ent_t;
  typedef ent_t eq_t[$];

  eq_t         qf, qn;
  logic [31:0] sf = '0, sn = '0;

  function automatic void predict(input eq_t q, input bit fwd, input bit use_,
                                  input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf,
                                  output logic [SEL_W-1:0] sel, output logic [XLEN-1:0] op,
                                  output bit haz);
    bit found = 0;
    bit rdy   = 0;
    int stg   = DEPTH;
    if (use_ && rs != 0)
      foreach (q[i])
        if (q[i].we && q[i].rd == rs && q[i].stage < stg) begin
          found = 1;
          stg   = q[i].stage;
          rdy   = q[i].stage >= (q[i].load ? LR : AR);
        end
    sel = '0;
    op  = rf;
    haz = 0;
    if (found) begin
      if (fwd && rdy) begin
        sel = SEL_W'(stg + 1);
        op  = stage_res[stg*XLEN +: XLEN];
      end else haz = 1;
    end
  endfunction

  function automatic eq_t advance(input eq_t q, input bit acc);
    eq_t  n;
    ent_t e;
    foreach (q[i]) begin
      e = q[i];
      if (flush && e.stage == 0) continue;
      if (!hold) e.stage++;
      if (e.stage < DEPTH) n.push_back(e);
    end
    if (!hold && acc) n.push_back('{stage: 0, rd: rd, we: rd_we, load: is_load});
    return n;
  endfunction

  task automatic score(input string tag, input eq_t q, input bit fwd, input logic [31:0] cnt,
                       input logic a_rdy, input logic [SEL_W-1:0] a_s1, a_s2,
                       input logic [XLEN-1:0] a_o1, a_o2, input logic [31:0] a_cnt,
                       output bit acc, output bit haz);
    logic [SEL_W-1:0] s1, s2;
    logic [XLEN-1:0]  o1, o2;
    bit               h1, h2, rdy;
    predict(q, fwd, use_rs1, rs1, rf_rs1_val, s1, o1, h1);
    predict(q, fwd, use_rs2, rs2, rf_rs2_val, s2, o2, h2);
    haz = issue_valid && (h1 || h2);
    rdy = !hold && !haz;
    check({tag, ".issue_ready"}, a_rdy, rdy);
    check({tag, ".fwd_sel1"}, a_s1, s1);
    check({tag, ".fwd_sel2"}, a_s2, s2);
    check({tag, ".op1"}, a_o1, o1);
    check({tag, ".op2"}, a_o2, o2);
    check({tag, ".stall_count"}, a_cnt, cnt);
    acc = issue_valid && rdy && !flush;
  endtask

  always @(negedge clock) begin
    bit af, hf, an, hn;
    if (!reset) begin
      qf.delete();
      qn.delete();
      sf = '0;
      sn = '0;
    end
    score("fwd", qf, 1'b1, sf, f_ready, f_sel1, f_sel2, f_op1, f_op2, f_stall, af, hf);
    score("nofwd", qn, 1'b0, sn, n_ready, n_sel1, n_sel2, n_op1, n_op2, n_stall, an, hn);
    if (reset) begin
      if (hf && !hold && !flush && sf != '1) sf++;
      if (hn && !hold && !flush && sn != '1) sn++;
      qf = advance(qf, af);
      qn = advance(qn, an);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    rf_rs1_val = $urandom;
    rf_rs2_val = $urandom;
    for (int k = 0; k < DEPTH; k++) stage_res[k*XLEN +: XLEN] = $urandom;
  endtask

  task automatic idle();
    issue_valid = 0; use_rs1 = 0; use_rs2 = 0; rs1 = '0; rs2 = '0; rd = '0;
    rd_we = 0; is_load = 0; hold = 0; flush = 0;
  endtask

  task automatic instr(input bit u1, input int r1, input bit u2, input int r2,
                       input int d, input bit we, input bit ld);
    issue_valid = 1; use_rs1 = u1; rs1 = RA_W'(r1); use_rs2 = u2; rs2 = RA_W'(r2);
    rd = RA_W'(d); rd_we = we; is_load = ld;
  endtask

  task automatic reset_dut();
    idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  initial begin
    idle();
    rf_rs1_val = 32'h1111_1111;
    rf_rs2_val = 32'h2222_2222;
    stage_res  = '0;
    reset      = 0;
    #1;
    check("reset.stall_fwd", f_stall, 0);
    check("reset.stall_nofwd", n_stall, 0);
    check("reset.ready_idle", f_ready, 1);
    instr(1, 5, 1, 6, 7, 1, 0);
    #1;
    check("reset.sel1_empty", f_sel1, 0);
    check("reset.op1_rf", f_op1, 32'h1111_1111);
    idle();
    tick();
    reset = 1;

    // ALU producer followed by dependent ADD: forwarded from stage 0.
    reset_dut();
    instr(1, 1, 1, 2, 5, 1, 0);
    tick();
    instr(1, 5, 1, 5, 6, 1, 0);
    #1;
    check("alu.ready", f_ready, 1);
    check("alu.sel1", f_sel1, 1);
    check("alu.sel2", f_sel2, 1);
    check("alu.op1", f_op1, stage_res[31:0]);
    check("alu.op2", f_op2, stage_res[31:0]);
    idle();
    repeat (4) tick();

    // Load-use: two stalls, then forwarded from the load stage.
    reset_dut();
    instr(1, 1, 0, 0, 7, 1, 1);
    tick();
    instr(1, 7, 1, 0, 8, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ld.stall_ready", f_ready, 0);
      check("ld.stall_cnt", f_stall, 32'(i));
      tick();
    end
    #1;
    check("ld.ready", f_ready, 1);
    check("ld.sel1", f_sel1, 3);
    check("ld.sel2", f_sel2, 0);
    check("ld.op1", f_op1, stage_res[95:64]);
    check("ld.cnt", f_stall, 2);
    idle();
    repeat (4) tick();

    // Without forwarding: stall until the producer retires.
    reset_dut();
    instr(1, 1, 0, 0, 3, 1, 0);
    tick();
    instr(1, 3, 1, 1, 4, 1, 0);
    #1;
    check("nf.fwd_sel1", f_sel1, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) #1;
      check("nf.stall_ready", n_ready, 0);
      check("nf.stall_cnt", n_stall, 32'(i));
      tick();
    end
    #1;
    check("nf.ready", n_ready, 1);
    check("nf.sel1", n_sel1, 0);
    check("nf.op1", n_op1, rf_rs1_val);
    check("nf.cnt", n_stall, 3);
    idle();
    repeat (4) tick();

    // x0 never creates a dependence; unused source fields are ignored.
    reset_dut();
    instr(1, 1, 0, 0, 0, 1, 0);
    tick();
    instr(1, 0, 1, 0, 12, 1, 0);
    #1;
    check("x0.ready_nf", n_ready, 1);
    check("x0.sel1_f", f_sel1, 0);
    check("x0.sel1_nf", n_sel1, 0);
    tick();
    instr(1, 1, 0, 0, 9, 1, 0);
    tick();
    instr(0, 9, 0, 9, 10, 1, 0);
    #1;
    check("lui.ready_nf", n_ready, 1);
    check("lui.sel1_f", f_sel1, 0);
    check("lui.sel2_f", f_sel2, 0);
    check("lui.op1_f", f_op1, rf_rs1_val);
    idle();
    repeat (4) tick();

    // Flush discards the stage-0 producer.
    reset_dut();
    instr(1, 1, 0, 0, 2, 1, 0);
    tick();
    idle();
    flush = 1;
    tick();
    flush = 0;
    instr(1, 2, 0, 0, 13, 1, 0);
    #1;
    check("flush.ready_nf", n_ready, 1);
    check("flush.sel1_f", f_sel1, 0);
    check("flush.sel1_nf", n_sel1, 0);
    idle();
    repeat (4) tick();

    // Flush coinciding with a load-use hazard: stall not counted.
    reset_dut();
    instr(1, 1, 0, 0, 7, 1, 1);
    tick();
    instr(1, 7, 0, 0, 8, 1, 0);
    flush = 1;
    #1;
    check("flhz.ready", f_ready, 0);
    tick();
    flush = 0;
    #1;
    check("flhz.cnt", f_stall, 0);
    check("flhz.ready_after", f_ready, 1);
    check("flhz.sel1_after", f_sel1, 0);
    idle();
    repeat (4) tick();

    // Hold during a load-use stall freezes the scoreboard and the counter.
    reset_dut();
    instr(1, 1, 0, 0, 7, 1, 1);
    tick();
    instr(1, 7, 0, 0, 8, 1, 0);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold.ready", f_ready, 0);
      check("hold.cnt", f_stall, 0);
      tick();
    end
    hold = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hold.rel_ready", f_ready, 0);
      check("hold.rel_cnt", f_stall, 32'(i));
      tick();
    end
    #1;
    check("hold.done_ready", f_ready, 1);
    check("hold.done_sel1", f_sel1, 3);
    check("hold.done_cnt", f_stall, 2);
    idle();
    repeat (4) tick();

    // Asynchronous reset with three valid entries and a nonzero stall count.
    reset_dut();
    instr(1, 1, 0, 0, 7, 1, 1);
    tick();
    instr(1, 7, 0, 0, 8, 1, 0);
    repeat (3) tick();
    instr(1, 1, 0, 0, 11, 1, 0);
    tick();
    instr(1, 1, 0, 0, 12, 1, 0);
    tick();
    instr(1, 12, 1, 11, 14, 1, 0);
    #1;
    check("ar.pre_cnt", f_stall, 2);
    check("ar.pre_sel1", f_sel1, 1);
    check("ar.pre_sel2", f_sel2, 2);
    reset = 0;
    #1;
    check("ar.cnt", f_stall, 0);
    check("ar.sel1", f_sel1, 0);
    check("ar.sel2", f_sel2, 0);
    check("ar.op1", f_op1, rf_rs1_val);
    check("ar.ready", f_ready, 1);
    tick();
    reset = 1;
    idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and operand-forwarding unit sitting between the register-read stage and the execute/memory/writeback pipeline of the core. It tracks the destination register and result readiness of every in-flight instruction, selects forwarded operands for the issuing instruction, and stalls issue only when a needed result is not yet produced. With forwarding disabled it reproduces the core's original stall-until-retired behaviour.

## Interface
- XLEN, 32: data width.
- RA_W, 5: register address width.
- DEPTH, 3: tracked stages after issue; stage 0 = execute, DEPTH-1 = writeback.
- ALU_READY, 0: first stage index at which a non-load result is valid on stage_res.
- LOAD_READY, 2: first stage index at which a load result is valid; LOAD_READY >= ALU_READY, both < DEPTH.
- FWD_EN, 1: 1 = forwarding; 0 = stall on any pending match.
- SEL_W, clog2(DEPTH+1): forward-select width.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- issue_valid  in  1  an instruction is presented at register read.
- issue_ready  out  1  instruction accepted this cycle (combinational).
- use_rs1, use_rs2  in  1  instruction reads rs1 / rs2 (0 for LUI/AUIPC/JAL).
- rs1, rs2  in  RA_W  source register addresses.
- rd  in  RA_W  destination register.
- rd_we  in  1  instruction writes rd.
- is_load  in  1  result comes from memory.
- hold  in  1  pipeline frozen (memory wait); no shift, no accept.
- flush  in  1  kill issuing instruction and stage-0 entry.
- rf_rs1_val, rf_rs2_val  in  XLEN  register-file read data.
- stage_res  in  DEPTH*XLEN  result bus, slice k = stage k.
- op1, op2  out  XLEN  selected operands (combinational).
- fwd_sel1, fwd_sel2  out  SEL_W  0 = register file, k+1 = stage k.
- stall_count  out  32  saturating count of hazard-stall cycles.

## Operation
- State: DEPTH entries {valid, rd, we, load}; all valid = 0 after reset.
- Match for rsN: use_rsN=1, rsN != 0, entry valid, we=1, entry rd == rsN. The youngest (lowest stage index) match wins.
- Ready: entry at stage k is ready if k >= (load ? LOAD_READY : ALU_READY).
- FWD_EN=1: youngest match ready -> fwd_selN = k+1, opN = stage_res slice k; youngest match not ready -> hazard. No match -> fwd_selN = 0, opN = rf_rsN_val.
- FWD_EN=0: any match -> hazard; fwd_selN always 0.
- issue_ready = !hold && !hazard. Hazard is evaluated only when issue_valid=1.
- Shift on every edge with hold=0: entry k -> k+1, entry DEPTH-1 retires. Stage 0 loads the issuing instruction if issue_valid && issue_ready && !flush, else a bubble (valid=0).
- flush with hold=0: stage 0 loads a bubble and the old stage-0 entry is discarded, not shifted into stage 1. flush with hold=1: stage-0 valid is cleared in place.
- hold=1: entries frozen; stall_count unchanged.
- stall_count increments when issue_valid && hazard && !hold && !flush, and saturates at 0xFFFF_FFFF.
- Register-file writes from stage DEPTH-1 complete at the edge. The retiring entry still forwards during its final cycle.

## Timing
- Reset (async assert, low): all valid = 0, stall_count = 0. Outputs follow the combinational rules with an empty scoreboard: fwd_sel = 0, op = rf values, issue_ready = !hold.
- Release is synchronous to the next clock edge; no state change occurs while reset is low.
- Scoreboard update latency is 1 cycle. Decision outputs are purely combinational from the inputs and current state.
- Dependent instruction issued immediately after its producer:
  - ALU producer, FWD_EN=1: 0 stalls, fwd_sel = 1.
  - Load producer, FWD_EN=1: LOAD_READY stalls, then fwd_sel = LOAD_READY+1.
  - FWD_EN=0: DEPTH stalls, then fwd_sel = 0.
- Simultaneous flush and hazard: flush takes priority; the stall is not counted.

## Test plan
- Defaults: ADD x5 issued, then ADD x6,x5,x5 next cycle -> issue_ready=1, fwd_sel1=fwd_sel2=1, op1 = stage_res[0].
- Load-use: LW x7, then ADD x8,x7,x0 -> issue_ready=0 for 2 cycles, then 1 with fwd_sel1=3; stall_count=2.
- FWD_EN=0: ADDI x3, then SUB x4,x3,x1 -> 3 stall cycles, then fwd_sel1=0, op1=rf_rs1_val.
- x0 and unused sources: producer with rd=0, consumer with rs1=0; and a LUI with use_rs1=0 after an x9 writer with rs1 field = 9 -> no stall, fwd_sel=0.
- flush: ADDI x2 in stage 0 with flush=1, consumer of x2 next cycle -> fwd_sel1=0, no stall.
- Mid-operation events: drop reset low with 3 valid entries -> all cleared asynchronously, stall_count=0. hold=1 during a load-use stall -> entries frozen and stall_count unchanged; hazard resolves 2 non-hold cycles after release.
